// File: rtl/neuron_seq_nbits.sv
// Sequential MAC neuron: K signed W*X beats plus bias, optional ReLU,
// arithmetic right shift by SHIFT, saturated to N bits.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   en                 global enable; when low all state holds
//   in_valid/in_ready  beat handshake for W, X, bias, act_relu
//   W, X               signed N-bit weight and input
//   bias               signed 2N-bit bias, taken on the first beat only
//   act_relu           1 = ReLU, 0 = linear, taken on the first beat only
//   out_valid/out_ready result handshake
//   Out                signed N-bit saturated result
//   busy               vector in progress or result pending
module neuron_seq_nbits #(
    parameter int N     = 8,
    parameter int K     = 4,
    parameter int SHIFT = N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [N-1:0]   W,
    input  logic signed [N-1:0]   X,
    input  logic signed [2*N-1:0] bias,
    input  logic                  act_relu,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [N-1:0]   Out,
    output logic                  busy
);

    localparam int ACC_W = 2*N + $clog2(K) + 1;
    localparam int CW    = (K > 1) ? $clog2(K) : 1;

    localparam logic signed [ACC_W-1:0] MAXV =
        ACC_W'((1 << (N-1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

    typedef enum logic {
        S_ACC,
        S_OUT
    } state_t;

    state_t                  state, state_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic signed [ACC_W-1:0] acc, acc_d;
    logic                    relu_q, relu_d;
    logic signed [N-1:0]     out_d;
    logic                    out_valid_d;

    logic signed [2*N-1:0]   prod;
    logic signed [ACC_W-1:0] prod_x;
    logic signed [ACC_W-1:0] bias_x;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] act;
    logic signed [ACC_W-1:0] shifted;
    logic signed [N-1:0]     sat;
    logic                    first;
    logic                    last;
    logic                    relu_eff;
    logic                    accept;
    logic                    take;

    assign in_ready = en & ~rst & (state == S_ACC);
    assign accept   = in_valid & in_ready;
    assign take     = en & out_ready & (state == S_OUT);
    assign busy     = (cnt != '0) | (state == S_OUT);

    assign first    = (cnt == '0);
    assign last     = (cnt == CW'(K-1));

    // Full-precision product and bias, sign-extended to the accumulator.
    assign prod     = W * X;
    assign prod_x   = {{(ACC_W-2*N){prod[2*N-1]}}, prod};
    assign bias_x   = {{(ACC_W-2*N){bias[2*N-1]}}, bias};

    // The first beat of a vector starts from the bias, not the old sum.
    assign base     = first ? bias_x : acc;
    assign relu_eff = first ? act_relu : relu_q;
    assign sum      = base + prod_x;

    assign act      = (relu_eff && sum[ACC_W-1]) ? '0 : sum;
    assign shifted  = act >>> SHIFT;

    always_comb begin
        sat = shifted[N-1:0];
        if (shifted > MAXV) begin
            sat = {1'b0, {(N-1){1'b1}}};
        end else if (shifted < MINV) begin
            sat = {1'b1, {(N-1){1'b0}}};
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        acc_d       = acc;
        relu_d      = relu_q;
        out_d       = Out;
        out_valid_d = out_valid;
        unique case (state)
            S_ACC: begin
                if (accept) begin
                    acc_d  = sum;
                    relu_d = relu_eff;
                    if (last) begin
                        cnt_d       = '0;
                        out_d       = sat;
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
            S_OUT: begin
                if (take) begin
                    out_valid_d = 1'b0;
                    state_d     = S_ACC;
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_ACC;
            cnt       <= '0;
            acc       <= '0;
            relu_q    <= 1'b0;
            Out       <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            state     <= state_d;
            cnt       <= cnt_d;
            acc       <= acc_d;
            relu_q    <= relu_d;
            Out       <= out_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_neuron_seq_nbits.sv
// Directed bench for neuron_seq_nbits with N=8, K=2, SHIFT=8.
// Expected values are hand-computed from the arithmetic definition.
module tb_neuron_seq_nbits;

    logic               clk;
    logic               rst;
    logic               en;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  W;
    logic signed [7:0]  X;
    logic signed [15:0] bias;
    logic               act_relu;
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  Out;
    logic               busy;

    int total;
    int bad;

    neuron_seq_nbits #(.N(8), .K(2), .SHIFT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .W         (W),
        .X         (X),
        .bias      (bias),
        .act_relu  (act_relu),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic signed [7:0] w,
                        input logic signed [7:0] x,
                        input logic signed [15:0] b,
                        input logic r);
        W        = w;
        X        = x;
        bias     = b;
        act_relu = r;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        step();
        step();
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_in_ready got=%b want=0", in_ready);
        end
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || Out !== 8'sd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got v=%b o=%0d b=%b want 0 0 0",
                     out_valid, Out, busy);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_relu();
        beat(-8'sd3, 8'sd2, 16'sd0, 1'b1);
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL relu_mid got v=%b b=%b want 0 1",
                     out_valid, busy);
        end
        beat(8'sd5, -8'sd4, 16'sd0, 1'b1);
        total++;
        if (out_valid !== 1'b1 || Out !== 8'sd0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL relu_neg got v=%b o=%0d r=%b want 1 0 0",
                     out_valid, Out, in_ready);
        end
        drain();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL relu_drain got v=%b b=%b want 0 0",
                     out_valid, busy);
        end
        beat(8'sd64, 8'sd2, 16'sd0, 1'b1);
        beat(8'sd64, 8'sd2, 16'sd0, 1'b1);
        total++;
        if (out_valid !== 1'b1 || Out !== 8'sd1) begin
            bad++;
            $display("FAIL relu_pos got v=%b o=%0d want 1 1", out_valid, Out);
        end
        drain();
    endtask

    task automatic test_linear_sat();
        beat(-8'sd128, -8'sd128, 16'sd0, 1'b0);
        beat(-8'sd128, -8'sd128, 16'sd0, 1'b0);
        total++;
        if (Out !== 8'sd127) begin
            bad++;
            $display("FAIL sat_pos got=%0d want=127", Out);
        end
        drain();
        beat(-8'sd128, 8'sd127, 16'sd0, 1'b0);
        beat(-8'sd128, 8'sd127, 16'sd0, 1'b0);
        total++;
        if (Out !== -8'sd127) begin
            bad++;
            $display("FAIL lin_neg got=%0d want=-127", Out);
        end
        drain();
        beat(-8'sd128, -8'sd128, 16'sh8000, 1'b0);
        beat(-8'sd128, -8'sd128, 16'sd0, 1'b0);
        total++;
        if (Out !== 8'sd0) begin
            bad++;
            $display("FAIL bias_min got=%0d want=0", Out);
        end
        drain();
        beat(-8'sd128, -8'sd128, 16'sh7fff, 1'b0);
        beat(-8'sd128, -8'sd128, 16'sd0, 1'b0);
        total++;
        if (Out !== 8'sd127) begin
            bad++;
            $display("FAIL bias_max got=%0d want=127", Out);
        end
        drain();
    endtask

    task automatic test_bias();
        beat(8'sd64, 8'sd2, -16'sd256, 1'b1);
        beat(8'sd64, 8'sd2, 16'sd0, 1'b1);
        total++;
        if (Out !== 8'sd0) begin
            bad++;
            $display("FAIL bias_neg got=%0d want=0", Out);
        end
        drain();
        beat(8'sd64, 8'sd2, 16'sd512, 1'b1);
        beat(8'sd64, 8'sd2, 16'sd0, 1'b1);
        total++;
        if (Out !== 8'sd3) begin
            bad++;
            $display("FAIL bias_pos got=%0d want=3", Out);
        end
        drain();
        beat(8'sd64, 8'sd2, 16'sd0, 1'b1);
        beat(8'sd64, 8'sd2, 16'sh7fff, 1'b1);
        total++;
        if (Out !== 8'sd1) begin
            bad++;
            $display("FAIL bias_late got=%0d want=1", Out);
        end
        drain();
        // Mode is latched on beat 1: linear -26 floors to -1.
        beat(-8'sd3, 8'sd2, 16'sd0, 1'b0);
        beat(8'sd5, -8'sd4, 16'sd0, 1'b1);
        total++;
        if (Out !== -8'sd1) begin
            bad++;
            $display("FAIL relu_late got=%0d want=-1", Out);
        end
        drain();
    endtask

    task automatic test_backpressure();
        beat(8'sd64, 8'sd2, 16'sd0, 1'b0);
        beat(8'sd64, 8'sd2, 16'sd0, 1'b0);
        W        = 8'sd1;
        X        = 8'sd1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (Out !== 8'sd1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got o=%0d v=%b r=%b want 1 1 0",
                         i, Out, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        drain();
        total++;
        if (busy !== 1'b0 || Out !== 8'sd1) begin
            bad++;
            $display("FAIL bp_release got b=%b o=%0d want 0 1", busy, Out);
        end
        beat(8'sd64, 8'sd2, 16'sd512, 1'b0);
        beat(8'sd64, 8'sd2, 16'sd0, 1'b0);
        total++;
        if (out_valid !== 1'b1 || Out !== 8'sd3) begin
            bad++;
            $display("FAIL bp_next got v=%b o=%0d want 1 3", out_valid, Out);
        end
        drain();
    endtask

    task automatic test_enable();
        beat(8'sd64, 8'sd2, 16'sd0, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            W        = 8'(i * 37 - 50);
            X        = 8'(90 - i * 13);
            bias     = 16'(i * 1000);
            in_valid = 1'b1;
            #1;
            total++;
            if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL en_hold%0d got r=%b b=%b v=%b want 0 1 0",
                         i, in_ready, busy, out_valid);
            end
            step();
        end
        in_valid = 1'b0;
        en = 1'b1;
        beat(8'sd64, 8'sd2, 16'sd0, 1'b1);
        total++;
        if (out_valid !== 1'b1 || Out !== 8'sd1) begin
            bad++;
            $display("FAIL en_result got v=%b o=%0d want 1 1", out_valid, Out);
        end
        en = 1'b0;
        drain();
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL en_outhold got v=%b want 1", out_valid);
        end
        en = 1'b1;
        drain();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL en_drain got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        beat(8'sd64, 8'sd2, 16'sd512, 1'b1);
        rst = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_ready got=%b want=0", in_ready);
        end
        step();
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || Out !== 8'sd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_state got v=%b o=%0d b=%b want 0 0 0",
                     out_valid, Out, busy);
        end
        beat(8'sd64, 8'sd2, 16'sd0, 1'b1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_stale got v=%b want 0", out_valid);
        end
        beat(8'sd64, 8'sd2, 16'sd0, 1'b1);
        total++;
        if (out_valid !== 1'b1 || Out !== 8'sd1) begin
            bad++;
            $display("FAIL rstmid_result got v=%b o=%0d want 1 1",
                     out_valid, Out);
        end
        drain();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        en        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        W         = '0;
        X         = '0;
        bias      = '0;
        act_relu  = 1'b0;
        test_reset();
        test_relu();
        test_linear_sat();
        test_bias();
        test_backpressure();
        test_enable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
